// File: rtl/sd_block_serdes_if.sv
// Block/byte handshake bundle between the SD test driver, the block serdes and the SPI byte engine.
// The slave view is the serdes; the master view is whoever drives the block and byte streams.
interface sd_block_serdes_if #(
    parameter int BlockBits = 4096
);
    logic [BlockBits-1:0] tx_block;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_byte;
    logic                 tx_byte_valid;
    logic                 tx_byte_ready;
    logic [7:0]           rx_byte;
    logic                 rx_byte_valid;
    logic                 rx_byte_ready;
    logic [BlockBits-1:0] rx_block;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_crc_error;
    logic                 busy;

    modport slave (
        input  tx_block, tx_valid, tx_byte_ready, rx_byte, rx_byte_valid, rx_ready,
        output tx_ready, tx_byte, tx_byte_valid, rx_byte_ready, rx_block, rx_valid,
        output rx_crc_error, busy
    );

    modport master (
        output tx_block, tx_valid, tx_byte_ready, rx_byte, rx_byte_valid, rx_ready,
        input  tx_ready, tx_byte, tx_byte_valid, rx_byte_ready, rx_block, rx_valid,
        input  rx_crc_error, busy
    );
endinterface

// File: rtl/sd_block_serdes.sv
// SD data block serialiser/deserialiser: 512-byte blocks MSB-first with SD CRC16 (x^16+x^12+x^5+1).
// Transmit and receive paths are independent and may run concurrently.
module sd_block_serdes #(
    parameter int BlockBits = 4096,
    parameter bit CrcEnable = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    sd_block_serdes_if.slave bus
);
    localparam int DataBytes = BlockBits / 8;
    localparam int CntBits   = (DataBytes > 1) ? $clog2(DataBytes) : 1;
    localparam logic [CntBits-1:0] LastCnt = CntBits'(DataBytes - 1);
    localparam logic [CntBits-1:0] CntOne  = CntBits'(1);

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_CRC_HI, TX_CRC_LO} tx_state_t;
    typedef enum logic [1:0] {RX_DATA, RX_CRC_HI, RX_CRC_LO, RX_HOLD} rx_state_t;

    tx_state_t            tx_state_r, tx_state_s;
    logic [BlockBits-1:0] tx_shift_r, tx_shift_adv_s;
    logic [CntBits-1:0]   tx_cnt_r;
    logic [15:0]          tx_crc_r, tx_crc_next_s;
    logic                 tx_fire_s, tx_last_s;

    rx_state_t            rx_state_r, rx_state_s;
    logic [BlockBits-1:0] rx_shift_r;
    logic [CntBits-1:0]   rx_cnt_r;
    logic [15:0]          rx_crc_r, rx_crc_next_s;
    logic [7:0]           rx_crc_hi_r;
    logic                 rx_valid_r, rx_crc_error_r;
    logic                 rx_fire_s, rx_last_s;

    // The CRC bytes ride out of the same shift register, so tx_byte always comes straight from a flop.
    assign bus.tx_ready      = (tx_state_r == TX_IDLE);
    assign bus.tx_byte_valid = (tx_state_r != TX_IDLE);
    assign bus.tx_byte       = tx_shift_r[BlockBits-1 -: 8];
    assign tx_fire_s         = bus.tx_byte_valid && bus.tx_byte_ready;
    assign tx_last_s         = (tx_cnt_r == LastCnt);
    assign tx_crc_next_s     = crc16_byte(tx_crc_r, tx_shift_r[BlockBits-1 -: 8]);

    // Tx shift value after a byte handshake; the final data byte loads the CRC into the top bits.
    always_comb begin
        tx_shift_adv_s = {tx_shift_r[BlockBits-9:0], 8'h00};
        if ((tx_state_r == TX_DATA) && tx_last_s && CrcEnable) begin
            tx_shift_adv_s = {tx_crc_next_s, {(BlockBits-16){1'b0}}};
        end else begin
            tx_shift_adv_s = {tx_shift_r[BlockBits-9:0], 8'h00};
        end
    end

    // Tx next-state logic.
    always_comb begin
        tx_state_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (bus.tx_valid) tx_state_s = TX_DATA;
                else              tx_state_s = TX_IDLE;
            end
            TX_DATA: begin
                if (tx_fire_s && tx_last_s) tx_state_s = CrcEnable ? TX_CRC_HI : TX_IDLE;
                else                        tx_state_s = TX_DATA;
            end
            TX_CRC_HI: begin
                if (tx_fire_s) tx_state_s = TX_CRC_LO;
                else           tx_state_s = TX_CRC_HI;
            end
            TX_CRC_LO: begin
                if (tx_fire_s) tx_state_s = TX_IDLE;
                else           tx_state_s = TX_CRC_LO;
            end
            default: tx_state_s = TX_IDLE;
        endcase
    end

    // Tx state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tx_state_r <= TX_IDLE;
        else          tx_state_r <= tx_state_s;
    end

    // Tx datapath: block load, byte shifting, CRC accumulation and byte count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift_r <= {BlockBits{1'b0}};
            tx_cnt_r   <= {CntBits{1'b0}};
            tx_crc_r   <= 16'h0000;
        end else if ((tx_state_r == TX_IDLE) && bus.tx_valid) begin
            tx_shift_r <= bus.tx_block;
            tx_cnt_r   <= {CntBits{1'b0}};
            tx_crc_r   <= 16'h0000;
        end else if (tx_fire_s) begin
            tx_shift_r <= tx_shift_adv_s;
            if (tx_state_r == TX_DATA) begin
                tx_crc_r <= tx_crc_next_s;
                if (!tx_last_s) tx_cnt_r <= tx_cnt_r + CntOne;
            end
        end
    end

    assign bus.rx_byte_ready = (rx_state_r != RX_HOLD);
    assign bus.rx_block      = rx_shift_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.rx_crc_error  = rx_crc_error_r;
    assign rx_fire_s         = bus.rx_byte_valid && bus.rx_byte_ready;
    assign rx_last_s         = (rx_cnt_r == LastCnt);
    assign rx_crc_next_s     = crc16_byte(rx_crc_r, bus.rx_byte);

    // Rx next-state logic.
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            RX_DATA: begin
                if (rx_fire_s && rx_last_s) rx_state_s = CrcEnable ? RX_CRC_HI : RX_HOLD;
                else                        rx_state_s = RX_DATA;
            end
            RX_CRC_HI: begin
                if (rx_fire_s) rx_state_s = RX_CRC_LO;
                else           rx_state_s = RX_CRC_HI;
            end
            RX_CRC_LO: begin
                if (rx_fire_s) rx_state_s = RX_HOLD;
                else           rx_state_s = RX_CRC_LO;
            end
            RX_HOLD: begin
                if (bus.rx_ready) rx_state_s = RX_DATA;
                else              rx_state_s = RX_HOLD;
            end
            default: rx_state_s = RX_DATA;
        endcase
    end

    // Rx state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rx_state_r <= RX_DATA;
        else          rx_state_r <= rx_state_s;
    end

    // Rx datapath: the count parks at the last index so busy stays high through the CRC bytes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift_r     <= {BlockBits{1'b0}};
            rx_cnt_r       <= {CntBits{1'b0}};
            rx_crc_r       <= 16'h0000;
            rx_crc_hi_r    <= 8'h00;
            rx_valid_r     <= 1'b0;
            rx_crc_error_r <= 1'b0;
        end else begin
            case (rx_state_r)
                RX_DATA: begin
                    if (rx_fire_s) begin
                        rx_shift_r <= {rx_shift_r[BlockBits-9:0], bus.rx_byte};
                        rx_crc_r   <= rx_crc_next_s;
                        if (!rx_last_s) rx_cnt_r <= rx_cnt_r + CntOne;
                        if (rx_last_s && !CrcEnable) begin
                            rx_valid_r     <= 1'b1;
                            rx_crc_error_r <= 1'b0;
                        end
                    end
                end
                RX_CRC_HI: begin
                    if (rx_fire_s) rx_crc_hi_r <= bus.rx_byte;
                end
                RX_CRC_LO: begin
                    if (rx_fire_s) begin
                        rx_valid_r     <= 1'b1;
                        rx_crc_error_r <= ({rx_crc_hi_r, bus.rx_byte} != rx_crc_r);
                    end
                end
                RX_HOLD: begin
                    if (bus.rx_ready) begin
                        rx_valid_r     <= 1'b0;
                        rx_crc_error_r <= 1'b0;
                        rx_cnt_r       <= {CntBits{1'b0}};
                        rx_crc_r       <= 16'h0000;
                    end
                end
                default: rx_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.busy = (tx_state_r != TX_IDLE) || (rx_cnt_r != {CntBits{1'b0}}) || rx_valid_r;

endmodule
